// File: rtl/alu_exec_if.sv
// Request/response bundle between the execute-stage pipeline control and alu_exec.
// The pipeline side is the master; the ALU is the slave.
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [3:0]      alucontrol;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            ready;
    logic            done;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output start, kill, alucontrol, a, b,
        input  ready, done, result, zero, illegal
    );

    modport slave (
        input  start, kill, alucontrol, a, b,
        output ready, done, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec.sv
// RV32I execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier that stalls the pipeline through the ready/done handshake.
module alu_exec #(
    parameter int XLEN = 32,
    parameter int CW   = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_exec_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1110;

    state_t          state_q;
    logic            ready_q;
    logic            done_q;
    logic            zero_q;
    logic            illegal_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [CW-1:0]   count_q;

    logic            accept;
    logic [XLEN-1:0] opResult_d;
    logic            opLegal_d;
    logic [XLEN-1:0] accSum_d;

    assign accept = (state_q == IDLE) && bus.start && !bus.kill;

    always_comb begin
        opResult_d = '0;
        opLegal_d  = 1'b1;
        case (bus.alucontrol)
            OP_AND:  opResult_d = bus.a & bus.b;
            OP_OR:   opResult_d = bus.a | bus.b;
            OP_ADD:  opResult_d = bus.a + bus.b;
            OP_SUB:  opResult_d = bus.a - bus.b;
            OP_SLL:  opResult_d = bus.a << bus.b[4:0];
            default: opLegal_d  = 1'b0;
        endcase
    end

    // Partial-product accumulate for the current multiplier bit.
    assign accSum_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bus.alucontrol == OP_MUL) begin
                            mcand_q  <= bus.a;
                            mplier_q <= bus.b;
                            acc_q    <= '0;
                            count_q  <= '0;
                            state_q  <= MUL;
                            ready_q  <= 1'b0;
                        end else begin
                            result_q  <= opLegal_d ? opResult_d : '0;
                            zero_q    <= opLegal_d ? (opResult_d == '0) : 1'b1;
                            illegal_q <= !opLegal_d;
                            done_q    <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // A flush wins over completion: drop the product silently.
                    if (bus.kill) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        count_q <= '0;
                    end else begin
                        acc_q    <= accSum_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        count_q  <= count_q + CW'(1);
                        if (count_q == CW'(XLEN - 1)) begin
                            result_q  <= accSum_d;
                            zero_q    <= (accSum_d == '0);
                            illegal_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= IDLE;
                            ready_q   <= 1'b1;
                            count_q   <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: accepted requests push the reference answer and
// its due cycle; an independent monitor pops and compares on every done pulse.
module tb_alu_exec;
    localparam int XLEN = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1110;

    typedef struct {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            illegal;
        int              due;
    } expect_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cycleCount = 0;
    int   checks = 0;
    int   errors = 0;

    expect_t         sbQ[$];
    logic [XLEN-1:0] lastResult;
    logic            lastZero;
    logic            lastIllegal;
    logic [3:0]      codes [10] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL, OP_MUL,
                                    4'b0011, 4'b0101, 4'b1111, 4'b1000};

    alu_exec_if #(.XLEN(XLEN)) bus();

    alu_exec #(.XLEN(XLEN), .CW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycleCount);
        end
    endtask

    // Reference behaviour straight from the operation table, using wide arithmetic.
    function automatic void refModel(input logic [3:0] code, input logic [XLEN-1:0] av,
                                     input logic [XLEN-1:0] bv,
                                     output logic [XLEN-1:0] r, output logic il);
        logic [63:0] prod;
        logic [4:0]  shamt;
        shamt = bv[4:0];
        il    = 1'b0;
        case (code)
            OP_AND: r = av & bv;
            OP_OR:  r = av | bv;
            OP_ADD: r = av + bv;
            OP_SUB: r = av - bv;
            OP_SLL: r = av << shamt;
            OP_MUL: begin
                prod = 64'(av) * 64'(bv);
                r    = prod[XLEN-1:0];
            end
            default: begin
                r  = '0;
                il = 1'b1;
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] code, input logic [XLEN-1:0] av,
                                 input logic [XLEN-1:0] bv, input bit track);
        expect_t         e;
        logic [XLEN-1:0] r;
        logic            il;
        bus.alucontrol = code;
        bus.a          = av;
        bus.b          = bv;
        bus.kill       = 1'b0;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (track) begin
            refModel(code, av, bv, r, il);
            e.result  = r;
            e.zero    = (r == '0);
            e.illegal = il;
            e.due     = cycleCount + ((code == OP_MUL) ? XLEN : 0);
            sbQ.push_back(e);
            lastResult  = r;
            lastZero    = (r == '0);
            lastIllegal = il;
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (sbQ.size() != 0 && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drainTimeout: got %0d pending results, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    always @(negedge clk) begin
        expect_t e;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            checkOutput("readyWithDone", 64'(bus.ready), 64'd1);
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d, expected no done",
                         cycleCount);
            end else begin
                e = sbQ.pop_front();
                checkOutput("result", 64'(bus.result), 64'(e.result));
                checkOutput("zero", 64'(bus.zero), 64'(e.zero));
                checkOutput("illegal", 64'(bus.illegal), 64'(e.illegal));
                checkOutput("latency", 64'(cycleCount), 64'(e.due));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]      code;
        logic [XLEN-1:0] av;
        logic [XLEN-1:0] bv;

        bus.start      = 1'b0;
        bus.kill       = 1'b0;
        bus.alucontrol = '0;
        bus.a          = '0;
        bus.b          = '0;
        rst_n          = 1'b0;
        lastResult     = '0;
        lastZero       = 1'b1;
        lastIllegal    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetReady", 64'(bus.ready), 64'd1);
        checkOutput("resetDone", 64'(bus.done), 64'd0);
        checkOutput("resetResult", 64'(bus.result), 64'd0);
        checkOutput("resetZero", 64'(bus.zero), 64'd1);
        checkOutput("resetIllegal", 64'(bus.illegal), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back single-cycle ops");
        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        applyStimulus(OP_SUB, 32'd5, 32'd7, 1'b1);
        applyStimulus(OP_SLL, 32'd1, 32'h25, 1'b1);
        applyStimulus(OP_AND, 32'hF0F0, 32'h0FF0, 1'b1);
        applyStimulus(OP_OR, 32'hF0F0, 32'h0FF0, 1'b1);
        waitDrain(10);

        $display("[TB] multiply with ignored starts while busy");
        applyStimulus(OP_MUL, 32'h12345, 32'h1000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bus.alucontrol = OP_ADD;
        bus.a          = 32'd7;
        bus.b          = 32'd9;
        bus.start      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("readyDuringMul", 64'(bus.ready), 64'd0);
        waitDrain(XLEN + 10);
        applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        waitDrain(XLEN + 10);
        applyStimulus(OP_MUL, 32'h1234, 32'd0, 1'b1);
        waitDrain(XLEN + 10);

        $display("[TB] kill mid-multiply");
        applyStimulus(OP_MUL, 32'd3, 32'd5, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        checkOutput("readyAfterKill", 64'(bus.ready), 64'd1);
        repeat (XLEN + 5) @(posedge clk);
        #1;
        checkOutput("resultAfterKill", 64'(bus.result), 64'(lastResult));
        checkOutput("zeroAfterKill", 64'(bus.zero), 64'(lastZero));

        $display("[TB] start with kill while idle");
        bus.alucontrol = OP_MUL;
        bus.a          = 32'd4;
        bus.b          = 32'd4;
        bus.start      = 1'b1;
        bus.kill       = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("readyStartKillMul", 64'(bus.ready), 64'd1);
        bus.alucontrol = OP_ADD;
        bus.a          = 32'd100;
        bus.b          = 32'd23;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("resultStartKillAdd", 64'(bus.result), 64'(lastResult));

        $display("[TB] kill on the completing edge");
        applyStimulus(OP_MUL, 32'd6, 32'd7, 1'b0);
        repeat (XLEN - 1) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        checkOutput("readyKillLastEdge", 64'(bus.ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("resultKillLastEdge", 64'(bus.result), 64'(lastResult));

        $display("[TB] illegal code then legal op");
        applyStimulus(4'b0011, 32'hDEAD, 32'hBEEF, 1'b1);
        applyStimulus(OP_ADD, 32'd2, 32'd3, 1'b1);
        waitDrain(10);

        $display("[TB] randomized ops");
        for (int i = 0; i < 60; i++) begin
            code = codes[$urandom_range(0, 9)];
            av   = $urandom;
            bv   = $urandom;
            if ($urandom_range(0, 3) == 0) bv = XLEN'($urandom_range(0, 3));
            applyStimulus(code, av, bv, 1'b1);
            if (code == OP_MUL) waitDrain(XLEN + 10);
        end
        waitDrain(10);

        $display("[TB] asynchronous reset during multiply");
        applyStimulus(OP_MUL, 32'd9, 32'd9, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetReady", 64'(bus.ready), 64'd1);
        checkOutput("asyncResetDone", 64'(bus.done), 64'd0);
        checkOutput("asyncResetResult", 64'(bus.result), 64'd0);
        checkOutput("asyncResetZero", 64'(bus.zero), 64'd1);
        checkOutput("asyncResetIllegal", 64'(bus.illegal), 64'd0);
        #3;
        rst_n = 1'b1;
        repeat (XLEN + 5) @(posedge clk);
        #1;
        applyStimulus(OP_ADD, 32'd1, 32'd2, 1'b1);
        waitDrain(10);

        checkOutput("queueEmpty", 64'(sbQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
